alu_sequencer: RTL and testbench
================================

# alu_sequencer

Instruction sequencer that drives the 8-bit ALU of the simple CPU. It accepts instruction bytes from the fetch side over a valid/ready handshake and decodes them. It issues a one-cycle `en` plus `operation` to the ALU and captures the ALU's registered result back into the accumulator (AC), which it owns and feeds to the ALU's `ac` input. It sits between instruction memory/fetch and the ALU, on the issuing side of the ALU's `en`/`operation`/`ac`/`alu_out` interface.

## Interface
- No parameters; all widths are fixed at 8-bit data and 4-bit opcode.
- `clk` input 1: system clock, rising-edge.
- `rst` input 1: one clock; reset is asynchronous and active-low.
- `instr_valid` input 1: fetch side presents a byte on `instr`.
- `instr` input 8: instruction or immediate byte.
- `instr_ready` output 1: sequencer accepts a byte this cycle. Combinational from state.
- `en` output 1: ALU start strobe.
- `operation` output 4: ALU operation code.
- `ac` output 8: accumulator, wired to the ALU `ac` input.
- `alu_out` input 8: registered ALU result.
- `busy` output 1: high in any state other than IDLE and HALT.
- `halted` output 1: HALT executed.
- `illegal` output 1: sticky flag, set on an undefined opcode.
- `zero` output 1: `ac == 8'h00`, combinational.
- `retired` output 8: count of completed instructions, wraps at 256.

## Operation
- Opcode is `instr[7:4]`. `instr[3:0]` is ignored for every opcode.
- Opcodes 0000–1001 are ALU ops, passed unchanged to `operation`:
  - 0000 MOVAC, 0001 MOVR, 0010 ADD, 0011 SUB, 0100 INAC
  - 0101 CLAC, 0110 AND, 0111 OR, 1000 XOR, 1001 NOT
- 1010 LDI: the next accepted byte is loaded directly into `ac`. The ALU is not used.
- 1011 NOP: retires with no other effect.
- 1100 HALT: enters HALT.
- 1101–1111 are illegal: set `illegal`, do not retire, leave `ac` unchanged.
- States and transitions:
  - IDLE: `instr_ready=1`. On `instr_valid`, latch `instr` into IR and go to DECODE.
  - DECODE:
    - ALU op goes to EXEC.
    - LDI goes to IMM.
    - NOP: `retired`+1, go to IDLE.
    - HALT: `retired`+1, go to HALT.
    - Illegal: set `illegal`, go to IDLE.
  - EXEC: `en=1`, `operation=IR[7:4]` for exactly this cycle. Go to WB.
  - WB: `ac <= alu_out`, `retired`+1, go to IDLE.
  - IMM: `instr_ready=1`. On `instr_valid`, `ac <= instr`, `retired`+1, go to IDLE. Waits indefinitely otherwise.
  - HALT: `instr_ready=0`, `halted=1`. Only reset exits.
- `operation` holds the last issued code outside EXEC; only `en` qualifies it.
- All arithmetic is modulo 256. `retired` wraps from 8'hFF to 8'h00.
- `illegal` is cleared only by reset.

## Timing
- Reset values:
  - state IDLE, IR 0.
  - `ac`=0, `en`=0, `operation`=0, `retired`=0, `illegal`=0, `halted`=0, `busy`=0.
  - `zero`=1 and `instr_ready`=1 while `rst` is high after reset.
- Handshake: a transfer occurs on a rising edge with `instr_valid && instr_ready`. `instr` need not be held after that edge.
- ALU op latency:
  - Edge 0 accepts the byte.
  - DECODE is cycle 1, EXEC cycle 2, WB cycle 3.
  - `ac` updates at the end of WB.
  - Next byte accepted at the earliest on edge 4, so throughput is 4 cycles per ALU instruction.
- The ALU registers its result on the edge that ends EXEC, so `alu_out` is valid throughout WB. This is the only cycle it is sampled.
- LDI: 2 cycles when the immediate is presented back-to-back; `ac` is valid the cycle after the immediate edge.
- NOP, HALT and illegal: 2 cycles from acceptance to the next state.
- `en` is never high outside EXEC and never high for 2 consecutive cycles.
- Reset asserted mid-operation (any state): immediate return to reset values. IR and any pending immediate are discarded, and `en` drops asynchronously.
- `instr_valid` asserted in DECODE, EXEC, WB or HALT is ignored; no byte is consumed.

## Test plan
- Reset check: assert `rst`=0 mid-EXEC. Required: `en`=0, `ac`=0, `retired`=0, `illegal`=0, `halted`=0 immediately. After release, `instr_ready`=1 and `zero`=1.
- Load and add, with the ALU instantiated alongside:
  - Stream 0xA0, 0x05, 0x00 (MOVAC), 0x40 (INAC), 0x20 (ADD).
  - Required `ac` after each instruction: 0x05, 0x05, 0x06, 0x0B. `retired`=4.
  - `en` pulses exactly 3 times with `operation` 0000, 0100, 0010.
- Wrap-around:
  - LDI 0xFF then INAC gives `ac`=0x00, `zero`=1.
  - 256 back-to-back NOPs (0xB0) from reset return `retired` to 0x00.
- Illegal opcode: send 0xE7 after LDI 0x33.
  - `illegal`=1 two cycles after acceptance; `ac`=0x33 and `retired` unchanged.
  - A following INAC still executes, giving `ac`=0x34.
- HALT: send 0xC0, then hold `instr_valid`=1 with 0x40 for 20 cycles.
  - `halted`=1, `instr_ready`=0, no `en` pulse, `ac` unchanged.
  - `rst` pulse restores IDLE.
- Handshake stalls:
  - LDI with a 5-cycle gap before the immediate: state stays IMM with `busy`=1, then `ac`=immediate.
  - `instr_valid` toggled during EXEC/WB is not consumed; verify `retired` and the accepted-byte count.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Fetch handshake and ALU issue bus of the sequencer.
// master: fetch/ALU side, slave: the sequencer.
interface alu_sequencer_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic       en;
  logic [3:0] operation;
  logic [7:0] ac;
  logic [7:0] alu_out;

  modport master (
    output instr_valid, instr, alu_out,
    input  instr_ready, en, operation, ac
  );

  modport slave (
    input  instr_valid, instr, alu_out,
    output instr_ready, en, operation, ac
  );
endinterface

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit ALU; owns AC.
// Ports: clk, rst (async low), bus (fetch+ALU), status outputs.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  alu_sequencer_if.slave bus,
  output logic       busy,
  output logic       halted,
  output logic       illegal,
  output logic       zero,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_IMM,
    S_HALT
  } state_t;

  state_t     state;
  state_t     next;
  logic [3:0] ir;
  logic [3:0] op_q;
  logic [7:0] ac;
  logic       is_alu;
  logic       is_ldi;
  logic       is_nop;
  logic       is_halt;
  logic       is_bad;
  logic       retire;

  assign is_alu  = ir <= 4'd9;
  assign is_ldi  = ir == 4'hA;
  assign is_nop  = ir == 4'hB;
  assign is_halt = ir == 4'hC;
  assign is_bad  = ir >= 4'hD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE: if (bus.instr_valid) next = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_alu:  next = S_EXEC;
          is_ldi:  next = S_IMM;
          is_nop:  next = S_IDLE;
          is_halt: next = S_HALT;
          default: next = S_IDLE;
        endcase
      end
      S_EXEC: next = S_WB;
      S_WB:   next = S_IDLE;
      S_IMM:  if (bus.instr_valid) next = S_IDLE;
      S_HALT: next = S_HALT;
      default: next = S_IDLE;
    endcase
  end

  assign retire = (state == S_DECODE && (is_nop || is_halt))
               || (state == S_WB)
               || (state == S_IMM && bus.instr_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir      <= 4'h0;
      op_q    <= 4'h0;
      ac      <= 8'h00;
      illegal <= 1'b0;
      retired <= 8'h00;
    end else begin
      if (state == S_IDLE && bus.instr_valid)
        ir <= bus.instr[7:4];
      // operation is loaded on entry to EXEC and then held
      if (state == S_DECODE && is_alu)
        op_q <= ir;
      if (state == S_DECODE && is_bad)
        illegal <= 1'b1;
      if (state == S_WB)
        ac <= bus.alu_out;
      else if (state == S_IMM && bus.instr_valid)
        ac <= bus.instr;
      if (retire)
        retired <= retired + 8'd1;
    end
  end

  assign bus.instr_ready = (state == S_IDLE)
                        || (state == S_IMM);
  assign bus.en        = state == S_EXEC;
  assign bus.operation = op_q;
  assign bus.ac        = ac;
  assign busy   = !(state == S_IDLE || state == S_HALT);
  assign halted = state == S_HALT;
  assign zero   = ac == 8'h00;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with an ALU and a reference model.
// Ports: none.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       halted;
  logic       illegal;
  logic       zero;
  logic [7:0] retired;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .busy    (busy),
    .halted  (halted),
    .illegal (illegal),
    .zero    (zero),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(
    input logic [3:0] op,
    input logic [7:0] a,
    input logic [7:0] r
  );
    case (op)
      4'd0:    return r;
      4'd1:    return a;
      4'd2:    return a + r;
      4'd3:    return a - r;
      4'd4:    return a + 8'd1;
      4'd5:    return 8'h00;
      4'd6:    return a & r;
      4'd7:    return a | r;
      4'd8:    return a ^ r;
      4'd9:    return ~a;
      default: return a;
    endcase
  endfunction

  // ALU next to the sequencer; operand register R starts at 5
  logic [7:0] alu_r;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.alu_out <= 8'h00;
      alu_r       <= 8'h05;
    end else if (bus.en) begin
      bus.alu_out <= alu_f(bus.operation, bus.ac, alu_r);
      if (bus.operation == 4'd1) alu_r <= bus.ac;
    end
  end

  // instruction-level model: cycles left per instruction
  int         m_cnt;
  logic       m_imm;
  logic       m_halt;
  logic       m_ill;
  logic [7:0] m_ac;
  logic [7:0] m_ret;
  logic [7:0] m_r;
  logic [3:0] m_op;
  logic [3:0] m_cur;
  int         m_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt  <= 0;
      m_imm  <= 1'b0;
      m_halt <= 1'b0;
      m_ill  <= 1'b0;
      m_ac   <= 8'h00;
      m_ret  <= 8'h00;
      m_r    <= 8'h05;
      m_op   <= 4'h0;
      m_cur  <= 4'h0;
    end else if (m_imm) begin
      if (bus.instr_valid) begin
        m_ac  <= bus.instr;
        m_ret <= m_ret + 8'd1;
        m_imm <= 1'b0;
      end
    end else if (!m_halt && m_cnt == 0) begin
      if (bus.instr_valid) begin
        m_cur <= bus.instr[7:4];
        m_cnt <= (bus.instr[7:4] <= 4'd9) ? 3 : 1;
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cur <= 4'd9) begin
        if (m_cnt == 3) m_op <= m_cur;
        if (m_cnt == 1) begin
          m_ac  <= alu_f(m_cur, m_ac, m_r);
          m_ret <= m_ret + 8'd1;
          if (m_cur == 4'd1) m_r <= m_ac;
        end
      end else begin
        case (m_cur)
          4'hA: m_imm <= 1'b1;
          4'hB: m_ret <= m_ret + 8'd1;
          4'hC: begin
            m_ret  <= m_ret + 8'd1;
            m_halt <= 1'b1;
          end
          default: m_ill <= 1'b1;
        endcase
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) m_acc <= m_acc;
    else if (bus.instr_valid && (m_imm || (!m_halt && m_cnt == 0)))
      m_acc <= m_acc + 1;
  end

  int         d_acc;
  int         en_cnt;
  logic [3:0] op_log[$];

  always @(posedge clk) begin
    if (rst && bus.instr_valid && bus.instr_ready)
      d_acc <= d_acc + 1;
    if (bus.en) begin
      en_cnt <= en_cnt + 1;
      op_log.push_back(bus.operation);
    end
  end

  int checks;
  int failures;
  int n_sent;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cmp_cycle();
    logic [25:0] act;
    logic [25:0] exp;
    act = {bus.instr_ready, bus.en, busy, halted, illegal,
           zero, bus.operation, bus.ac, retired};
    exp = {!m_halt && (m_imm || m_cnt == 0),
           m_cnt == 2 && m_cur <= 4'd9,
           m_cnt != 0 || m_imm, m_halt, m_ill,
           m_ac == 8'h00, m_op, m_ac, m_ret};
    chk("cycle", {6'd0, act}, {6'd0, exp});
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    #1;
    bus.instr_valid = 1'b1;
    bus.instr       = b;
    n = 0;
    while (!bus.instr_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.instr_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_ready required=ready");
    end else begin
      n_sent++;
      @(posedge clk);
      #1;
    end
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.instr_ready && !busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=busy required=idle");
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  int e0;
  int q0;

  initial begin
    checks          = 0;
    failures        = 0;
    n_sent          = 0;
    d_acc           = 0;
    m_acc           = 0;
    en_cnt          = 0;
    rst             = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;

    fork
      forever begin
        @(negedge clk);
        cmp_cycle();
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_ac", {24'd0, bus.ac}, 32'h00);
    chk("rst_ret", {24'd0, retired}, 32'h00);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rel_zero", {31'd0, zero}, 32'd1);

    e0 = en_cnt;
    q0 = op_log.size();
    send(8'hA0);
    send(8'h05);
    chk("ldi_ac", {24'd0, bus.ac}, 32'h05);
    send(8'h00);
    wait_done();
    chk("movac_ac", {24'd0, bus.ac}, 32'h05);
    send(8'h40);
    wait_done();
    chk("inac_ac", {24'd0, bus.ac}, 32'h06);
    send(8'h20);
    wait_done();
    chk("add_ac", {24'd0, bus.ac}, 32'h0B);
    chk("add_ret", {24'd0, retired}, 32'd4);
    chk("en_pulses", en_cnt - e0, 32'd3);
    if (op_log.size() >= q0 + 3) begin
      chk("op0", {28'd0, op_log[q0]}, 32'h0);
      chk("op1", {28'd0, op_log[q0+1]}, 32'h4);
      chk("op2", {28'd0, op_log[q0+2]}, 32'h2);
    end else begin
      checks++;
      failures++;
      $display("FAIL op_log actual=%0d required=3",
               op_log.size() - q0);
    end

    send(8'hA0);
    send(8'hFF);
    send(8'h40);
    wait_done();
    chk("wrap_ac", {24'd0, bus.ac}, 32'h00);
    chk("wrap_zero", {31'd0, zero}, 32'd1);

    send(8'hA0);
    send(8'h33);
    send(8'hE7);
    @(negedge clk);
    chk("ill_early", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    chk("ill_set", {31'd0, illegal}, 32'd1);
    chk("ill_ac", {24'd0, bus.ac}, 32'h33);
    chk("ill_ret", {24'd0, retired}, 32'd7);
    send(8'h40);
    wait_done();
    chk("ill_inac", {24'd0, bus.ac}, 32'h34);
    chk("ill_sticky", {31'd0, illegal}, 32'd1);

    send(8'hA0);
    send(8'h10);
    send(8'h40);
    @(posedge clk);
    #1;
    chk("exec_en", {31'd0, bus.en}, 32'd1);
    chk("exec_ret", {24'd0, retired}, 32'd9);
    rst = 1'b0;
    #1;
    chk("mid_en", {31'd0, bus.en}, 32'd0);
    chk("mid_ac", {24'd0, bus.ac}, 32'h00);
    chk("mid_ret", {24'd0, retired}, 32'd0);
    chk("mid_ill", {31'd0, illegal}, 32'd0);
    chk("mid_halt", {31'd0, halted}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("mid_zero", {31'd0, zero}, 32'd1);

    e0 = en_cnt;
    send(8'hC0);
    @(negedge clk);
    #1;
    bus.instr_valid = 1'b1;
    bus.instr       = 8'h40;
    repeat (20) @(negedge clk);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("halt_en", en_cnt - e0, 32'd0);
    chk("halt_ac", {24'd0, bus.ac}, 32'h00);
    chk("halt_ret", {24'd0, retired}, 32'd1);
    #1;
    bus.instr_valid = 1'b0;
    pulse_rst();
    @(negedge clk);
    chk("halt_exit", {31'd0, halted}, 32'd0);
    chk("halt_idle", {31'd0, bus.instr_ready}, 32'd1);

    send(8'hA0);
    repeat (5) begin
      @(negedge clk);
      chk("gap_busy", {31'd0, busy}, 32'd1);
    end
    send(8'h5A);
    chk("gap_ac", {24'd0, bus.ac}, 32'h5A);

    send(8'h40);
    @(negedge clk);
    #1;
    bus.instr_valid = 1'b1;
    bus.instr       = 8'hB0;
    @(negedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    #1;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    #1;
    bus.instr_valid = 1'b0;
    wait_done();
    chk("tog_ac", {24'd0, bus.ac}, 32'h5B);
    chk("tog_ret", {24'd0, retired}, 32'd2);
    chk("tog_acc", d_acc, n_sent);

    pulse_rst();
    repeat (256) send(8'hB0);
    wait_done();
    chk("nop_ret", {24'd0, retired}, 32'd0);
    chk("nop_ac", {24'd0, bus.ac}, 32'h00);
    chk("acc_total", d_acc, n_sent);
    chk("acc_model", d_acc, m_acc);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
